// File: rtl/aes_pkg.sv
// Shared types and constants for the AES plaintext block packer.
package aes_pkg;

    localparam int BLK_W  = 128;
    localparam int CODE_W = 16;
    localparam int ACC_W  = BLK_W + CODE_W;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_PAD,
        ST_DRAIN,
        ST_DONE
    } pack_state_e;

    // ISO/IEC 7816-4 style pad: a single 1 bit, then zeros.
    localparam logic [BLK_W-1:0] ISO_PAD_BLK = {1'b1, {(BLK_W-1){1'b0}}};

    // Lengths above the maximum codeword width are treated as full width.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'(CODE_W)) ? 5'(CODE_W) : len;
    endfunction

    // Moves the len valid bits of a right-justified codeword to the top of the word.
    function automatic logic [CODE_W-1:0] left_justify(input logic [CODE_W-1:0] data,
                                                       input logic [4:0]        len);
        logic [CODE_W-1:0] mask;
        mask = (len >= 5'(CODE_W)) ? '1 : ((CODE_W'(1) << len) - CODE_W'(1));
        return (data & mask) << (5'(CODE_W) - len);
    endfunction

endpackage

// File: rtl/aes_pack_outreg.sv
// 128-bit output holding register for the block packer; holds data stable under backpressure.
module aes_pack_outreg
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BLK_W-1:0] load_data,
    input  logic             load_last,
    input  logic             blk_ready,
    output logic             blk_valid,
    output logic [0:BLK_W-1] blk_data,
    output logic             blk_last,
    output logic             free
);

    assign free = !blk_valid || blk_ready;

    // NOTE: sequential state is always written with non-blocking assignments.
    // NOTE: the wide data register is reset because blk_data must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            blk_data  <= '0;
        end else if (load) begin
            blk_valid <= 1'b1;
            blk_last  <= load_last;
            blk_data  <= load_data;
        end else if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_block_packer.sv
// Packs variable-length Huffman codewords MSB-first into 128-bit AES plaintext blocks.
// Define AES_PACKER_ISO_PAD_EN to pad with a 1 bit plus zeros instead of zeros only.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int BLK_W  = aes_pkg::BLK_W,
    parameter int CODE_W = aes_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_data,
    input  logic [4:0]        code_len,
    input  logic              code_last,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [0:BLK_W-1]  blk_data,
    output logic              blk_last,
    output logic              done
);

`ifdef AES_PACKER_ISO_PAD_EN
    localparam bit ISO_EN = 1'b1;
`else
    localparam bit ISO_EN = 1'b0;
`endif

    pack_state_e       state, state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        fill;
    logic [4:0]        len_eff;
    logic [CODE_W-1:0] code_left;
    logic [ACC_W-1:0]  ins;
    logic              full, accept, do_xfer, do_pad, load_last, out_free;
    logic [BLK_W-1:0]  load_data;

    // acc is left-aligned: acc[ACC_W-1] is the oldest unsent stream bit.
    assign len_eff   = clamp_len(code_len);
    assign code_left = left_justify(code_data, len_eff);
    assign ins       = {code_left, {BLK_W{1'b0}}} >> fill;
    assign full      = fill >= 8'(BLK_W);
    assign accept    = code_valid && code_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && code_last) state_nxt = ST_PAD;
            ST_PAD:   if (!full && (do_pad || (!ISO_EN && fill == 8'd0))) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!blk_valid || blk_ready) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        code_ready = 1'b0;
        done       = 1'b0;
        do_xfer    = 1'b0;
        do_pad     = 1'b0;
        load_last  = 1'b0;
        case (state)
            ST_ACCUM: begin
                code_ready = !rst && !full;
                do_xfer    = full && out_free;
            end
            ST_PAD: begin
                if (full) begin
                    do_xfer   = out_free;
                    load_last = !ISO_EN && (fill == 8'(BLK_W));
                end else begin
                    // A zero-pad with no remaining bits produces no block at all.
                    do_pad    = out_free && (ISO_EN || fill != 8'd0);
                    load_last = 1'b1;
                end
            end
            ST_DONE:  done = !rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            fill <= '0;
        end else if (accept) begin
            acc  <= acc | ins;
            fill <= fill + 8'(len_eff);
        end else if (do_xfer) begin
            acc  <= acc << BLK_W;
            fill <= fill - 8'(BLK_W);
        end else if (do_pad) begin
            acc  <= '0;
            fill <= '0;
        end
    end

    // Bits beyond fill are always zero, so zero padding is implicit in acc.
    assign load_data = acc[ACC_W-1 -: BLK_W] |
                       ((do_pad && ISO_EN) ? (ISO_PAD_BLK >> fill) : {BLK_W{1'b0}});

    aes_pack_outreg u_outreg (
        .clk       (clk),
        .rst       (rst),
        .load      (do_xfer || do_pad),
        .load_data (load_data),
        .load_last (load_last),
        .blk_ready (blk_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .free      (out_free)
    );

endmodule

// File: tb/tb_aes_block_packer.sv
// Randomized self-checking bench for aes_block_packer against a bit-queue stream model.
module tb_aes_block_packer;

`ifdef AES_PACKER_ISO_PAD_EN
    localparam bit ISO = 1'b1;
`else
    localparam bit ISO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         code_valid, code_ready, code_last;
    logic [15:0]  code_data;
    logic [4:0]   code_len;
    logic         blk_valid, blk_ready, blk_last, done;
    logic [0:127] blk_data;

    always #5 clk = ~clk;

    aes_block_packer dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .code_len   (code_len),
        .code_last  (code_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .done       (done)
    );

    typedef struct {
        logic [127:0] data;
        bit           last;
    } blk_t;

    blk_t exp_q[$];
    blk_t got_q[$];
    bit   stream_bits[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ready_pct = 100;
    int gap_max   = 0;
    int first_valid_cyc = -1;
    bit hold_ready = 1'b0;
    bit last_acc   = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a flat stream of bits cut into 128-bit blocks.
    task automatic emit(input bit last);
        blk_t b;
        for (int i = 0; i < 128; i++) b.data[127-i] = stream_bits.pop_front();
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic model_accept(input logic [15:0] d, input logic [4:0] l, input bit last);
        int n;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = n - 1; i >= 0; i--) stream_bits.push_back(d[i]);
        if (stream_bits.size() >= 128) emit(last && stream_bits.size() == 128 && !ISO);
        if (last && (stream_bits.size() > 0 || ISO)) begin
            if (ISO) stream_bits.push_back(1'b1);
            while (stream_bits.size() < 128) stream_bits.push_back(1'b0);
            emit(1'b1);
        end
    endtask

    // One clock: entered at a falling edge with inputs set, sampled 1 time unit later.
    task automatic tick();
        logic [127:0] bd;
        blk_t         e;
        blk_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        #1;
        last_acc = code_valid && code_ready;
        if (blk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (blk_valid && blk_ready) begin
            bd = blk_data;
            got_q.push_back('{data: bd, last: blk_last});
            check("blk_pending", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("blk_data", bd, e.data);
                check("blk_last", 128'(blk_last), 128'(e.last));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_drained", 128'(exp_q.size()), 128'd0);
            check("done_outreg_empty", 128'(blk_valid), 128'd0);
        end
        if (last_acc) model_accept(code_data, code_len, code_last);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_code(input logic [15:0] d, input logic [4:0] l, input bit last);
        code_valid = 1'b1;
        code_data  = d;
        code_len   = l;
        code_last  = last;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (last_acc) break;
        end
        check("code_accepted", 128'(last_acc), 128'd1);
        code_valid = 1'b0;
        code_data  = 16'($urandom);
        code_len   = 5'($urandom);
        code_last  = 1'($urandom);
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        code_valid = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (done_cnt != start) break;
        end
        check("done_seen", 128'(done_cnt - start), 128'd1);
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        code_valid = 1'b0;
        blk_ready  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_code_ready", 128'(code_ready), 128'd0);
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_last", 128'(blk_last), 128'd0);
        check("rst_blk_data", blk_data, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_code_ready", 128'(code_ready), 128'd1);
        check("post_rst_blk_valid", 128'(blk_valid), 128'd0);
        stream_bits.delete();
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  aligned_codes [8];
        logic [15:0]  rst_codes [8];
        logic [127:0] rst_block;
        int           acc_cyc;
        int           n;
        logic [4:0]   l;

        aligned_codes = '{16'h0107, 16'h1f7f, 16'h0107, 16'h1f7f,
                          16'h0003, 16'h0f3f, 16'h0003, 16'h0f3f};
        rst = 1'b1;
        code_valid = 1'b0;
        code_data  = '0;
        code_len   = '0;
        code_last  = 1'b0;
        blk_ready  = 1'b0;
        reset_dut();

        // Aligned stream, sink always ready, plus the completing-codeword latency.
        ready_pct = 100;
        gap_max   = 0;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) first_valid_cyc = -1;
            send_code(aligned_codes[i], 5'd16, i == 7);
        end
        acc_cyc = cyc - 1;
        wait_done();
        check("aligned_latency", 128'(first_valid_cyc - acc_cyc), 128'd2);
        check("aligned_nblk", 128'(got_q.size()), ISO ? 128'd2 : 128'd1);
        if (got_q.size() > 0) begin
            check("aligned_blk0", got_q[0].data, 128'h01071f7f01071f7f00030f3f00030f3f);
            check("aligned_blk0_last", 128'(got_q[0].last), ISO ? 128'd0 : 128'd1);
        end
        if (ISO && got_q.size() > 1) begin
            check("aligned_pad_blk", got_q[1].data, 128'h80000000000000000000000000000000);
            check("aligned_pad_last", 128'(got_q[1].last), 128'd1);
        end

        // Block-spanning codeword with a random sink.
        ready_pct = 50;
        got_q.delete();
        for (int i = 0; i < 7; i++) send_code(16'hffff, 5'd16, 1'b0);
        send_code(16'h0abc, 5'd12, 1'b0);
        send_code(16'h0def, 5'd12, 1'b1);
        wait_done();
        check("span_nblk", 128'(got_q.size()), 128'd2);
        if (got_q.size() == 2) begin
            check("span_blk0", got_q[0].data, 128'hffffffffffffffffffffffffffffabcd);
            check("span_blk0_last", 128'(got_q[0].last), 128'd0);
            check("span_blk1", got_q[1].data,
                  ISO ? 128'hef800000000000000000000000000000 : 128'hef000000000000000000000000000000);
            check("span_blk1_last", 128'(got_q[1].last), 128'd1);
        end

        // Backpressure: two full blocks pile up while the sink is stalled.
        hold_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 16; i++) send_code(16'($urandom), 5'd16, 1'b0);
        repeat (10) tick();
        check("bp_code_ready", 128'(code_ready), 128'd0);
        check("bp_blk_valid", 128'(blk_valid), 128'd1);
        hold_ready = 1'b0;
        ready_pct  = 100;
        send_code(16'($urandom), 5'd8, 1'b1);
        wait_done();
        check("bp_nblk", 128'(got_q.size()), 128'd3);

        // Empty stream.
        got_q.delete();
        send_code(16'($urandom), 5'd0, 1'b1);
        wait_done();
        check("empty_nblk", 128'(got_q.size()), ISO ? 128'd1 : 128'd0);
        if (ISO && got_q.size() > 0) begin
            check("empty_pad_blk", got_q[0].data, 128'h80000000000000000000000000000000);
            check("empty_pad_last", 128'(got_q[0].last), 128'd1);
        end

        // Reset in the middle of a block discards the partial data.
        for (int i = 0; i < 5; i++) send_code(16'($urandom), 5'd16, 1'b0);
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            rst_codes[i] = 16'($urandom);
            rst_block    = {rst_block[111:0], rst_codes[i]};
            send_code(rst_codes[i], 5'd16, i == 7);
        end
        wait_done();
        check("rst_nblk", 128'(got_q.size()), ISO ? 128'd2 : 128'd1);
        if (got_q.size() > 0) check("rst_blk0", got_q[0].data, rst_block);

        // Random streams with odd lengths, gaps and a random sink.
        gap_max = 2;
        for (int s = 0; s < 8; s++) begin
            ready_pct = $urandom_range(30, 100);
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0:       l = (i == n - 1) ? 5'd1 : 5'd0;
                    1:       l = 5'($urandom_range(17, 31));
                    default: l = 5'($urandom_range(1, 16));
                endcase
                send_code(16'($urandom), l, i == n - 1);
            end
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Bit-stream-to-block packer between the Huffman encoder and `enc_aes`. Accepts variable-length Huffman codewords (1–16 bits) on a valid/ready interface. Packs them MSB-first into 128-bit plaintext blocks and presents each block to the AES stage with a valid/ready handshake. On end-of-stream it pads the final partial block, flags it last, and pulses `done`.

## Interface
Parameters:
- `BLK_W`, 128: block width; fixed by AES, not meant to be overridden.
- `CODE_W`, 16: maximum codeword length.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `code_valid`  in  1  codeword present.
- `code_ready`  out  1  packer can accept a codeword this cycle.
- `code_data`  in  16  codeword, right-justified; `code_data[code_len-1]` is sent first.
- `code_len`  in  5  bit count. 1..16 are legal. 0 contributes no bits. 17..31 are treated as 16.
- `code_last`  in  1  this codeword ends the stream.
- `blk_valid`  out  1  block available.
- `blk_ready`  in  1  AES stage takes the block.
- `blk_data`  out  [0:127]  plaintext block; bit 0 is the first stream bit, in the same orientation as `enc_aes` input.
- `blk_last`  out  1  block is the final one of the stream.
- `done`  out  1  one-cycle pulse once the stream is fully drained.

## Operation
- Datapath:
  - 144-bit accumulator `acc`, left-aligned, plus fill counter `fill` (0..144, 8 bits).
  - 128-bit output holding register with `blk_valid`/`blk_last`.
- Accept (`code_valid && code_ready`): codeword bits go into `acc[fill +: len]` MSB-first, and `fill += len`.
- Transfer: when `fill >= 128` and the output register is free (`!blk_valid || blk_ready`):
  - `acc[0:127]` moves to `blk_data`.
  - `acc` shifts left by 128 and `fill -= 128`.
- FSM states: ACCUM, PAD, DRAIN, DONE.
- ACCUM:
  - `code_ready = (fill < 128)`; transfers happen as above.
  - Accepting a codeword with `code_last = 1` → PAD.
- PAD:
  - `code_ready = 0`.
  - If `fill >= 128`, first perform a full-block transfer with `blk_last = 0`, or with `blk_last = 1` when the remainder is 0 and the ISO pad is off. Stay in PAD.
  - Then, once `fill < 128`, apply padding (see Configuration) → DRAIN.
  - If there is nothing to pad and no pad block is required, go straight to DRAIN with no extra block.
- DRAIN: wait for the final block handshake (`blk_valid && blk_ready && blk_last`) → DONE. If no block was ever flagged last, i.e. an empty stream with the ISO pad off, → DONE immediately.
- DONE:
  - `done = 1` for one cycle, then → ACCUM with `fill = 0`.
  - The next codeword starts a new stream at bit 0.
- `blk_data` must stay stable while `blk_valid && !blk_ready`.

## Timing
- Reset values: `blk_valid = 0`, `blk_last = 0`, `blk_data = 0`, `done = 0`, `code_ready = 0` while `rst = 1`, `fill = 0`, state ACCUM.
- `code_ready` is combinational from state and `fill`; it reads 1 in the first cycle after `rst` falls.
- Latency: a codeword that completes a block, accepted at edge k, gives `blk_valid = 1` from edge k+1, provided the output register is free.
- Throughput: one codeword per cycle while `fill < 128`. Each transfer costs at most one cycle of `code_ready = 0`.
- Backpressure: with `blk_ready = 0`, a second full block stays in `acc` (`fill >= 128`) and `code_ready` remains 0. No bits are ever lost or overwritten.
- Simultaneous output handshake and transfer in the same cycle: the new block loads with no bubble.
- Reset mid-operation: the partial block and any pending output are discarded, and all registers return to reset values on the next edge.

## Configuration
- With `AES_PACKER_ISO_PAD_EN` defined:
  - Padding appends a single `1` bit followed by zeros up to 128.
  - If the remainder is 0, an extra block `80000000_00000000_00000000_00000000` (`blk_last = 1`) is always emitted.
- Without the macro:
  - Padding is zeros only, and no extra block is emitted when the stream is block-aligned.
  - An empty stream produces no block; only `done`.

## Structure
- Shared package `aes_pkg`:
  - `BLK_W`, `CODE_W`.
  - Packer state enum.
  - Padding constant `ISO_PAD_BLK`.
- Optional sub-module `aes_pack_outreg`: the 128-bit holding register with valid/ready skid logic. Everything else stays in `aes_block_packer`.

## Test plan
- Aligned stream: eight 16-bit codes `0107, 1f7f, 0107, 1f7f, 0003, 0f3f, 0003, 0f3f`, last on the eighth.
  - Expect one block `01071f7f01071f7f00030f3f00030f3f` with `blk_last = 1` when ISO is off.
  - With ISO on, that block has `blk_last = 0`, followed by `800…0` with `blk_last = 1`.
- Spanning: seven codes `FFFF`, then len 12 `ABC`, then len 12 `DEF` with last.
  - Expect block 0 = `FFFF…FFFF_ABCD` (`blk_last = 0`).
  - Expect block 1 = `EF00…0` with ISO off, or `EF80…0` with ISO on; `blk_last = 1` either way.
- Backpressure: hold `blk_ready = 0` for 10 cycles while sending two blocks of codes.
  - `code_ready` drops once `fill >= 128`.
  - After release, both blocks emerge in order and bit-exact.
- Empty stream: first transfer is `code_len = 0`, `code_last = 1`.
  - ISO off: no `blk_valid`, `done` pulses.
  - ISO on: single block `800…0` with `blk_last = 1`, then `done`.
- Reset mid-block: accept 5 codes of 16 bits, then `rst = 1` for one cycle.
  - Expect `blk_valid = 0` and `code_ready = 1` after release.
  - The next 8 codes form a block starting at bit 0 with no residue.
